// File: rtl/reorder_buffer.sv
// 8-entry in-order reorder buffer: allocates at tail, completes on write-back,
// retires from head one per cycle, and squashes younger entries on mispredict.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [4:0]        disp_areg,
  input  logic [PREG_W-1:0] disp_prd,
  input  logic [PREG_W-1:0] disp_old_prd,
  input  logic [31:0]       disp_pc,
  input  logic              disp_is_store,
  output logic              rob_ready,
  output logic [IDX_W-1:0]  disp_rob_idx,
  input  logic              WB_in_valid,
  input  logic [IDX_W-1:0]  WB_in_rob_idx,
  input  logic [31:0]       WB_in_data,
  input  logic              mispredict,
  input  logic [IDX_W-1:0]  mis_rob_idx,
  output logic              cm_valid,
  output logic [4:0]        cm_areg,
  output logic [PREG_W-1:0] cm_prd,
  output logic [PREG_W-1:0] cm_old_prd,
  output logic [31:0]       cm_data,
  output logic [31:0]       cm_pc,
  output logic              cm_is_store,
  output logic              rob_empty
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, done_q, store_q;
  logic [4:0]        areg_q    [DEPTH];
  logic [PREG_W-1:0] prd_q     [DEPTH];
  logic [PREG_W-1:0] old_prd_q [DEPTH];
  logic [31:0]       pc_q      [DEPTH];
  logic [31:0]       data_q    [DEPTH];
  logic [IDX_W-1:0]  head_q, tail_q;
  logic [IDX_W:0]    count_q, count_next;

  logic              accept;
  logic [IDX_W-1:0]  mis_age;
  logic [DEPTH-1:0]  squash;

  assign rob_ready    = count_q < FULL_COUNT;
  assign rob_empty    = count_q == '0;
  assign disp_rob_idx = tail_q;
  assign accept       = disp_valid && rob_ready && !mispredict;

  assign cm_valid    = valid_q[head_q] && done_q[head_q];
  assign cm_areg     = areg_q[head_q];
  assign cm_prd      = prd_q[head_q];
  assign cm_old_prd  = old_prd_q[head_q];
  assign cm_data     = data_q[head_q];
  assign cm_pc       = pc_q[head_q];
  assign cm_is_store = store_q[head_q];

  // Age is distance from head, so comparisons stay correct across index wrap.
  always_comb begin
    mis_age = mis_rob_idx - head_q;
    squash  = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      squash[i] = mispredict && (IDX_W'(IDX_W'(i) - head_q) > mis_age);
    if (mispredict)
      count_next = {1'b0, mis_age} + (IDX_W+1)'(1) - (IDX_W+1)'(cm_valid);
    else
      count_next = count_q + (IDX_W+1)'(accept) - (IDX_W+1)'(cm_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      store_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        areg_q[i]    <= '0;
        prd_q[i]     <= '0;
        old_prd_q[i] <= '0;
        pc_q[i]      <= '0;
        data_q[i]    <= '0;
      end
    end else begin
      if (accept) begin
        valid_q[tail_q]   <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        areg_q[tail_q]    <= disp_areg;
        prd_q[tail_q]     <= disp_prd;
        old_prd_q[tail_q] <= disp_old_prd;
        pc_q[tail_q]      <= disp_pc;
        store_q[tail_q]   <= disp_is_store;
      end
      if (WB_in_valid && valid_q[WB_in_rob_idx] && !squash[WB_in_rob_idx]) begin
        done_q[WB_in_rob_idx] <= 1'b1;
        data_q[WB_in_rob_idx] <= WB_in_data;
      end
      if (cm_valid)
        valid_q[head_q] <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash[i]) begin
          valid_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
      end
      head_q  <= head_q + IDX_W'(cm_valid);
      tail_q  <= mispredict ? mis_rob_idx + IDX_W'(1) : tail_q + IDX_W'(accept);
      count_q <= count_next;
    end
  end

  mis_idx_valid_a: assert property (@(posedge clk) disable iff (rst)
    mispredict |-> valid_q[mis_rob_idx]);

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts
// commits (with cycle stamps) and status; a monitor checks each retirement.
module tb_reorder_buffer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [4:0]  areg;
    logic [6:0]  prd;
    logic [6:0]  old;
    logic [31:0] pc;
    logic        st;
    logic        done;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    int          cyc;
    logic [4:0]  areg;
    logic [6:0]  prd;
    logic [6:0]  old;
    logic [31:0] pc;
    logic [31:0] data;
    logic        st;
  } exp_t;

  logic        clk, rst;
  logic        disp_valid, disp_is_store, rob_ready, rob_empty;
  logic [4:0]  disp_areg, cm_areg;
  logic [6:0]  disp_prd, disp_old_prd, cm_prd, cm_old_prd;
  logic [31:0] disp_pc, WB_in_data, cm_data, cm_pc;
  logic [2:0]  disp_rob_idx, WB_in_rob_idx, mis_rob_idx;
  logic        WB_in_valid, mispredict, cm_valid, cm_is_store;

  ent_t       mq[$];
  exp_t       eq[$];
  logic [2:0] m_tail;
  int         cyc;
  int         n_total, n_pass;

  reorder_buffer #(.DEPTH(8), .IDX_W(3), .PREG_W(7)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_areg(disp_areg), .disp_prd(disp_prd),
    .disp_old_prd(disp_old_prd), .disp_pc(disp_pc), .disp_is_store(disp_is_store),
    .rob_ready(rob_ready), .disp_rob_idx(disp_rob_idx),
    .WB_in_valid(WB_in_valid), .WB_in_rob_idx(WB_in_rob_idx), .WB_in_data(WB_in_data),
    .mispredict(mispredict), .mis_rob_idx(mis_rob_idx),
    .cm_valid(cm_valid), .cm_areg(cm_areg), .cm_prd(cm_prd), .cm_old_prd(cm_old_prd),
    .cm_data(cm_data), .cm_pc(cm_pc), .cm_is_store(cm_is_store), .rob_empty(rob_empty)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus: check status, drive inputs, advance the model.
  task automatic step(input bit dv, input logic [31:0] pc, input bit wv, input logic [2:0] wi,
                      input bit mis, input logic [2:0] mi);
    ent_t e, w;
    exp_t x;
    int mpos;
    bit ready, commit;
    logic [31:0] wd;
    @(negedge clk);
    chk("rob_ready", 32'(rob_ready), 32'(mq.size() < 8));
    chk("rob_empty", 32'(rob_empty), 32'(mq.size() == 0));
    chk("disp_rob_idx", 32'(disp_rob_idx), 32'(m_tail));
    e.idx = m_tail;
    e.areg = 5'($urandom);
    e.prd = 7'($urandom);
    e.old = 7'($urandom);
    e.pc = pc;
    e.st = 1'($urandom);
    e.done = 1'b0;
    e.data = '0;
    wd = $urandom;
    disp_valid = dv; disp_areg = e.areg; disp_prd = e.prd; disp_old_prd = e.old;
    disp_pc = pc; disp_is_store = e.st;
    WB_in_valid = wv; WB_in_rob_idx = wi; WB_in_data = wd;
    mispredict = mis; mis_rob_idx = mi;

    ready  = mq.size() < 8;
    commit = mq.size() > 0 && mq[0].done;
    if (commit) begin
      x.cyc = cyc; x.areg = mq[0].areg; x.prd = mq[0].prd; x.old = mq[0].old;
      x.pc = mq[0].pc; x.data = mq[0].data; x.st = mq[0].st;
      eq.push_back(x);
    end
    mpos = -1;
    if (mis)
      for (int k = 0; k < mq.size(); k++) if (mq[k].idx == mi) mpos = k;
    if (wv)
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].idx == wi && (!mis || k <= mpos)) begin
          w = mq[k]; w.done = 1'b1; w.data = wd; mq[k] = w;
        end
    if (mis) begin
      while (mq.size() > mpos + 1) w = mq.pop_back();
      m_tail = mi + 3'd1;
    end
    if (commit) w = mq.pop_front();
    if (dv && ready && !mis) begin
      mq.push_back(e);
      m_tail = m_tail + 3'd1;
    end
  endtask

  task automatic drain();
    bit wv;
    logic [2:0] wi;
    for (int n = 0; n < 60; n++) begin
      if (mq.size() == 0) return;
      wv = 1'b0; wi = '0;
      for (int k = mq.size() - 1; k >= 0; k--)
        if (!mq[k].done) begin wv = 1'b1; wi = mq[k].idx; end
      step(0, 0, wv, wi, 0, 0);
    end
    chk("drain_timeout", 32'(mq.size()), 0);
  endtask

  // Reset pulsed between edges within an idle cycle.
  task automatic reset_mid(input bit expect_commit);
    step(0, 0, 0, 0, 0, 0);
    #4;
    if (expect_commit) chk("cm_valid_before_rst", 32'(cm_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_cm_valid", 32'(cm_valid), 0);
    chk("rst_rob_empty", 32'(rob_empty), 1);
    chk("rst_rob_ready", 32'(rob_ready), 1);
    chk("rst_disp_rob_idx", 32'(disp_rob_idx), 0);
    chk("rst_cm_pc", cm_pc, 0);
    chk("rst_cm_data", cm_data, 0);
    #1 rst = 1'b0;
    mq.delete();
    m_tail = '0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (cm_valid === 1'b1) begin
        if (eq.size() == 0) chk("cm_unexpected", 32'(cm_valid), 0);
        else begin
          x = eq.pop_front();
          chk("cm_cycle", cyc, x.cyc);
          chk("cm_pc", cm_pc, x.pc);
          chk("cm_data", cm_data, x.data);
          chk("cm_areg", 32'(cm_areg), 32'(x.areg));
          chk("cm_prd", 32'(cm_prd), 32'(x.prd));
          chk("cm_old_prd", 32'(cm_old_prd), 32'(x.old));
          chk("cm_is_store", 32'(cm_is_store), 32'(x.st));
        end
      end else if (eq.size() > 0 && eq[0].cyc == cyc) begin
        chk("cm_missing", 32'(cm_valid), 1);
        x = eq.pop_front();
      end
    end
  end

  initial begin : driver
    bit dv, wv, mis;
    logic [2:0] wi, mi;
    int und[$];
    n_total = 0; n_pass = 0; cyc = 0; m_tail = '0;
    rst = 1'b1;
    disp_valid = 0; disp_areg = '0; disp_prd = '0; disp_old_prd = '0; disp_pc = '0;
    disp_is_store = 0; WB_in_valid = 0; WB_in_rob_idx = '0; WB_in_data = '0;
    mispredict = 0; mis_rob_idx = '0;
    #3;
    chk("init_rob_ready", 32'(rob_ready), 1);
    chk("init_rob_empty", 32'(rob_empty), 1);
    chk("init_disp_rob_idx", 32'(disp_rob_idx), 0);
    chk("init_cm_valid", 32'(cm_valid), 0);
    chk("init_cm_pc", cm_pc, 0);
    #4 rst = 1'b0;

    // Fill, dispatch while full, write back in order, drain.
    for (int i = 0; i < 8; i++) step(1, 32'(i * 4), 0, 0, 0, 0);
    step(1, 32'h20, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), 0, 0);
    drain();

    // Out-of-order completion.
    reset_mid(0);
    for (int i = 0; i < 3; i++) step(1, 32'h40 + 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 1, 3'd2, 0, 0);
    step(0, 0, 1, 3'd1, 0, 0);
    step(0, 0, 1, 3'd0, 0, 0);
    drain();

    // Mispredict at idx 2 with a same-cycle write-back to squashed idx 4.
    reset_mid(0);
    for (int i = 0; i < 6; i++) step(1, 32'h80 + 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 1, 3'd4, 1, 3'd2);
    step(1, 32'h100, 0, 0, 0, 0);
    drain();

    // Wrap-around then flush at idx 7.
    reset_mid(0);
    for (int i = 0; i < 6; i++) step(1, 32'h200 + 32'(i * 4), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 3'(i), 0, 0);
    drain();
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7);
    step(0, 0, 0, 0, 0, 0);
    drain();

    // Full with head done: dispatch refused in the commit cycle, accepted next.
    reset_mid(0);
    for (int i = 0; i < 8; i++) step(1, 32'h400 + 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 1, 3'd0, 0, 0);
    step(1, 32'h500, 0, 0, 0, 0);
    step(1, 32'h504, 0, 0, 0, 0);
    drain();

    // Async reset with four entries and a commit in flight.
    reset_mid(0);
    for (int i = 0; i < 4; i++) step(1, 32'h600 + 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 1, 3'd0, 0, 0);
    reset_mid(1);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      dv = $urandom_range(0, 9) < 6;
      wv = 1'b0; wi = '0; mis = 1'b0; mi = '0;
      und.delete();
      for (int k = 0; k < mq.size(); k++) if (!mq[k].done) und.push_back(k);
      if (und.size() > 0 && $urandom_range(0, 1) == 1) begin
        wv = 1'b1;
        wi = mq[und[$urandom_range(0, und.size() - 1)]].idx;
      end
      if (mq.size() > 0 && $urandom_range(0, 24) == 0) begin
        mis = 1'b1;
        mi = mq[$urandom_range(0, mq.size() - 1)].idx;
      end
      step(dv, $urandom & 32'hFFFF_FFFC, wv, wi, mis, mi);
    end
    drain();
    step(0, 0, 0, 0, 0, 0);
    #3;
    chk("scoreboard_drained", 32'(eq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
